// File: rtl/pcp_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone carry network.
// The prefix operator and the level/stage derivations live here so every file agrees on them.
package pcp_pkg;

  localparam int PCP_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // (G,P) o (G',P'): hi is the more significant group, lo the adjacent lower one.
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int pcp_levels(input int width);
    return $clog2(width);
  endfunction

  function automatic int pcp_lat(input int levels, input int levels_per_stage);
    return (levels + levels_per_stage - 1) / levels_per_stage;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: bit i absorbs bit i-SPAN; bits below SPAN pass through.
module prefix_level
  import pcp_pkg::*;
#(
  parameter int WIDTH = PCP_WIDTH,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_comb
      assign {g_out[i], p_out[i]} = pg_combine(pg_t'({g_in[i], p_in[i]}),
                                               pg_t'({g_in[i-SPAN], p_in[i-SPAN]}));
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network: Pi/Gi/cin in, sum/difference, carry-out and zero flag out.
// LEVELS_PER_STAGE prefix levels sit between registers; the last stage also applies cin.
module prefix_carry_pipe
  import pcp_pkg::*;
#(
  parameter int WIDTH            = PCP_WIDTH,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pi,
  input  logic [WIDTH-1:0] gi,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             eq
);

  localparam int LEVELS = pcp_levels(WIDTH);
  localparam int LAT    = pcp_lat(LEVELS, LEVELS_PER_STAGE);
  localparam int NREG   = (LAT > 1) ? LAT - 1 : 1;

  logic [LEVELS-1:0][WIDTH-1:0] lin_g, lin_p, lout_g, lout_p;
  logic [NREG-1:0][WIDTH-1:0]   rg_g, rg_p, rg_pi;
  logic [NREG-1:0]              rg_cin;
  logic [LAT-1:0][WIDTH-1:0]    stg_pi;
  logic [LAT-1:0]               stg_cin;
  logic [LAT-1:0]               vld, adv, vin;
  logic                         chain;
  logic [WIDTH:0]               carry;
  logic [WIDTH-1:0]             fin_res;

  // Prefix levels; a level that starts a new stage reads the previous stage's registers.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    if (k == 0) begin : g_src_in
      assign lin_g[k] = gi;
      assign lin_p[k] = pi;
    end else if (k % LEVELS_PER_STAGE == 0) begin : g_src_reg
      assign lin_g[k] = rg_g[k/LEVELS_PER_STAGE-1];
      assign lin_p[k] = rg_p[k/LEVELS_PER_STAGE-1];
    end else begin : g_src_lvl
      assign lin_g[k] = lout_g[k-1];
      assign lin_p[k] = lout_p[k-1];
    end
    prefix_level #(.WIDTH(WIDTH), .SPAN(1 << k)) u_level (
      .g_in (lin_g[k]),
      .p_in (lin_p[k]),
      .g_out(lout_g[k]),
      .p_out(lout_p[k])
    );
  end

  // Handshake: a beat moves on an edge where the sender's valid and the receiver's ready
  // are both high. A stage is ready when empty or when the stage after it advances; the
  // output stage is ready when empty or out_ready. Readiness is combinational end to end,
  // so bubbles anywhere collapse in the same cycle.
  always_comb begin
    adv   = '0;
    chain = out_ready;
    for (int s = LAT - 1; s >= 0; s--) begin
      chain  = chain || !vld[s];
      adv[s] = chain;
    end
  end

  always_comb begin
    vin        = '0;
    stg_pi     = '0;
    stg_cin    = '0;
    vin[0]     = in_valid;
    stg_pi[0]  = pi;
    stg_cin[0] = cin;
    for (int s = 1; s < LAT; s++) begin
      vin[s]     = vld[s-1];
      stg_pi[s]  = rg_pi[s-1];
      stg_cin[s] = rg_cin[s-1];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[LAT-1];

  // Group G/P now spans [i:0], so c[i+1] = G[i:0] | P[i:0]&cin.
  assign carry   = {lout_g[LEVELS-1] | (lout_p[LEVELS-1] & {WIDTH{stg_cin[LAT-1]}}),
                    stg_cin[LAT-1]};
  assign fin_res = stg_pi[LAT-1] ^ carry[WIDTH-1:0];

  // Data registers load only with a valid beat, so idle-cycle inputs never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      rg_g   <= '0;
      rg_p   <= '0;
      rg_pi  <= '0;
      rg_cin <= '0;
      res    <= '0;
      cout   <= 1'b0;
      eq     <= 1'b0;
    end else begin
      for (int s = 0; s < LAT; s++) begin
        if (adv[s]) vld[s] <= vin[s];
      end
      for (int s = 0; s < LAT - 1; s++) begin
        if (adv[s] && vin[s]) begin
          rg_g[s]   <= lout_g[(s+1)*LEVELS_PER_STAGE-1];
          rg_p[s]   <= lout_p[(s+1)*LEVELS_PER_STAGE-1];
          rg_pi[s]  <= stg_pi[s];
          rg_cin[s] <= stg_cin[s];
        end
      end
      if (adv[LAT-1] && vin[LAT-1]) begin
        res  <= fin_res;
        cout <= carry[WIDTH];
        eq   <= ~|fin_res;
      end
    end
  end

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Self-checking bench for prefix_carry_pipe: directed vectors, backpressure, throughput, reset.
// Expected results come from plain 65-bit addition a + ~b + cin.
module tb_prefix_carry_pipe;

  localparam int W   = 64;
  localparam int LAT = 3;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] r;
    logic         co;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] pi = '0;
  logic [W-1:0] gi = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         cout;
  logic         eq;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         out_cnt = 0;
  int         first_out = 0;
  int         last_out = 0;
  bit         lat_chk = 1'b0;

  prefix_carry_pipe u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pi       (pi),
    .gi       (gi),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .cout     (cout),
    .eq       (eq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model and checkers ----------------
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c};
  endfunction

  task automatic check_v(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    pi       = a ^ ~b;
    gi       = a & ~b;
    cin      = c;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int  guard;
    bit  took;
    guard = 0;
    took  = 1'b0;
    drive(a, b, c);
    while (!took) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        exp_q.push_back(model(a, b, c));
        acc_q.push_back(cyc);
      end else if (++guard > 50) begin
        check_i("accept_timeout", guard, 0);
        break;
      end
    end
  endtask

  // Idle cycle with junk on the data inputs; it must never reach a valid result.
  task automatic idle();
    in_valid = 1'b0;
    pi       = {$urandom, $urandom};
    gi       = {$urandom, $urandom};
    cin      = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle();
    check_i("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check_v("spurious_out", {cout, res}, '0);
      end else begin
        check_v("result", {cout, res}, exp_q[0]);
        check_v("eq", (W+1)'(eq), (W+1)'(exp_q[0][W-1:0] == '0));
        if (out_ready) begin
          if (lat_chk) check_i("latency", cyc - acc_q[0], LAT - 1);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          out_cnt++;
          if (out_cnt == 1) first_out = cyc;
          last_out = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs[6];
    int   acc;
    int   first_acc;
    int   last_acc;
    bit   took;
    logic [W-1:0] ra, rb;

    vecs[0] = '{64'd5, 64'd3, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[1] = '{64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 1'b1, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{64'd1, 64'd0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[5] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_i("rst_out_valid", int'(out_valid), 0);
    check_i("rst_in_ready", int'(in_ready), 1);
    check_v("rst_res", (W+1)'(res), '0);
    check_i("rst_cout", int'(cout), 0);
    check_i("rst_eq", int'(eq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: pin the model to hand values, then run them through the DUT
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    foreach (vecs[i]) begin
      check_v("model_pin", model(vecs[i].a, vecs[i].b, vecs[i].c), {vecs[i].co, vecs[i].r});
      check_i("model_pin_eq", int'(model(vecs[i].a, vecs[i].b, vecs[i].c) == {vecs[i].co, {W{1'b0}}}),
              int'(vecs[i].z));
      send(vecs[i].a, vecs[i].b, vecs[i].c);
      if (i % 2 == 1) idle();
    end
    drain();

    // Backpressure: output blocked, offer 5 beats
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    out_cnt   = 0;
    acc       = 0;
    for (int k = 0; k < 8; k++) begin
      drive(64'd100 + 64'(acc), 64'(acc), 1'b1);
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        exp_q.push_back(model(64'd100 + 64'(acc), 64'(acc), 1'b1));
        acc_q.push_back(cyc);
        acc++;
      end
    end
    check_i("bp_accepts", acc, LAT);
    check_i("bp_in_ready_low", int'(in_ready), 0);
    out_ready = 1'b1;
    for (int k = acc; k < 5; k++) send(64'd100 + 64'(k), 64'(k), 1'b1);
    drain();
    check_i("bp_out_count", out_cnt, 5);

    // Throughput: 200 back-to-back random beats
    lat_chk   = 1'b1;
    out_cnt   = 0;
    first_acc = 0;
    last_acc  = 0;
    for (int k = 0; k < 200; k++) begin
      ra = {$urandom, $urandom};
      rb = (k % 16 == 0) ? ra : {$urandom, $urandom};
      send(ra, rb, 1'($urandom_range(0, 1)));
      if (k == 0) first_acc = cyc;
      last_acc = cyc;
    end
    drain();
    check_i("tp_accept_span", last_acc - first_acc, 199);
    check_i("tp_out_count", out_cnt, 200);
    check_i("tp_out_span", last_out - first_out, 199);

    // Reset mid-stream with the pipeline full
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < LAT; k++) send(64'hDEAD_0000 + 64'(k), 64'h1, 1'b1);
    in_valid = 1'b0;
    check_i("pre_rst_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_i("mid_rst_out_valid", int'(out_valid), 0);
    check_i("mid_rst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    out_cnt   = 0;
    send(vecs[0].a, vecs[0].b, vecs[0].c);
    drain();
    check_i("post_rst_out_count", out_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefix_carry_pipe.md
Name: prefix_carry_pipe

Overview:
- Pipelined parallel-prefix (Kogge-Stone) carry network, directly downstream of the per-bit propagate/generate stage.
- Consumes that stage's 64-bit Pi/Gi vectors, which encode a + ~b, plus a carry-in.
- Produces the difference/sum, the carry-out and an equality flag for the generator datapath.
- Valid/ready handshake on both sides; full throughput of one result per cycle.

Parameters:
- WIDTH, 64, operand width in bits; must be a power of two ≥ 4.
- LEVELS_PER_STAGE, 2, number of prefix levels evaluated between pipeline registers.
- LEVELS, $clog2(WIDTH), total prefix levels; derived, not overridable.
- LAT, ceil(LEVELS/LEVELS_PER_STAGE), number of register stages (3 by default); derived.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  Pi/Gi/cin valid
- in_ready  out  1  stage 0 can accept this cycle
- pi  in  WIDTH  per-bit propagate (a XOR ~b)
- gi  in  WIDTH  per-bit generate (a AND ~b)
- cin  in  1  carry-in; 1 for subtraction a-b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- res  out  WIDTH  Pi XOR carry vector (a-b when cin=1)
- cout  out  1  carry out of bit WIDTH-1; 1 means a ≥ b unsigned
- eq  out  1  res == 0

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0; out_valid=0, res=0, cout=0, eq=0. Data registers clear to 0. in_ready is combinational and reads 1 while in reset.
- Carry definition: c[0]=cin; c[i+1] = G[i:0] | (P[i:0] & cin), where P[i:0] is the AND of pi[i..0].
  - res[i] = pi[i] ^ c[i].
  - cout = c[WIDTH].
  - eq = ~|res.
- Prefix operator: (G,P)∘(G',P') = (G | P&G', P&P'). Level k combines bit i with bit i-2^k for i ≥ 2^k; bits below 2^k pass through unchanged.
- Stage s register holds: valid, group G/P after levels up to (s+1)·LEVELS_PER_STAGE-1, original pi, cin.
  - The final stage applies cin, forms res/cout/eq and registers them as the output.
  - The last stage runs only the remaining levels.
- Latency: a beat accepted at edge t appears at out_valid at edge t+LAT-1 if unstalled. Default: accepted cycle 0, visible after 3 edges.
- Handshake:
  - stage s advances when !valid[s] || advance[s+1]; the output stage advances when !out_valid || out_ready.
  - in_ready = advance[0], which is combinational back-propagation, so bubbles collapse.
  - A transfer occurs only when valid && ready at the same edge.
- Stall: while a stage holds a beat and does not advance, its registers are stable. No beat is dropped, duplicated or reordered.
- Simultaneous events: output drain and input accept in the same cycle both happen; the pipeline stays full at 1 beat/cycle.
- in_valid=0 creates bubbles: the valid bits clear, but the data registers need not change.
- Capacity: at most LAT beats in flight.
- Reset asserted mid-operation discards all in-flight beats immediately. The first accept after release is a fresh beat.
- Inputs pi/gi/cin are X-tolerant when in_valid=0: they must not propagate into valid outputs.

Decomposition:
- Shared package pcp_pkg:
  - WIDTH default constant.
  - pg_t struct {g,p}.
  - pg_combine function implementing ∘.
  - LEVELS/LAT derivation functions.
- Sub-module prefix_level (combinational, parameter SPAN=2^k): applies one Kogge-Stone level to G/P vectors. Instantiated LEVELS times; pipeline registers live in prefix_carry_pipe.

Test Plan:
- Bench computes pi=a^~b, gi=a&~b. a=5, b=3, cin=1 -> after 3 cycles res=0x2, cout=1, eq=0.
- a=3, b=5, cin=1 -> res=0xFFFF_FFFF_FFFF_FFFE, cout=0, eq=0. a=b=0x8000_0000_0000_0000 -> res=0, cout=1, eq=1.
- Full carry chain: a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, cin=0 -> res=0xFFFF_FFFF_FFFF_FFFF, cout=0, eq=0.
- Backpressure: hold out_ready=0 and offer 5 beats -> in_ready falls after exactly 3 accepts. Release out_ready -> 5 results in order, none lost.
- Throughput: 200 random beats with out_ready=1 and in_valid=1 continuously -> one result per cycle after the 3-cycle latency; all results match a reference model.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately. After release, the first result corresponds to the first post-reset beat.
